adder_op_sequencer: RTL and testbench
=====================================

// Module: adder_op_sequencer
// PURPOSE
//  FSM that sequences two-operand entry for the 8-bit adder/display datapath from one switch bank and one step button.
//  Captures operand A, then operand B, computes {cout,sum}, and holds the result for the hex decoders.
//  Returns to idle on a button press or a hold timeout.
//  Sits between the board switches/button and the hex display decoders.
// PARAMETERS
//  WIDTH        8           operand/sum width in bits
//  HOLD_CYCLES  50_000_000  SHOW timeout in clk cycles; 0 = timeout disabled
// PORTS
//  clk           in   1      system clock, rising edge
//  areset        in   1      asynchronous reset, active-low
//  in            in   WIDTH  operand switches
//  btn           in   1      raw step button, active-high, asynchronous to clk
//  clr           in   1      synchronous clear, active-high
//  a_out         out  WIDTH  captured operand A
//  b_out         out  WIDTH  captured operand B
//  sum           out  WIDTH  (a_out + b_out) mod 2^WIDTH
//  cout          out  1      carry out of the last add
//  result_valid  out  1      high while in SHOW
//  state         out  2      IDLE=00, HAVE_A=01, HAVE_B=10, SHOW=11; display mux select
//  ovf_cnt       out  4      count of adds that produced a carry; saturates at 15
// BEHAVIOUR
//  Reset (areset=0): all outputs 0, state=IDLE, hold counter 0, btn sync FFs 0.
//  Edge-detect "previous" FF resets to 1, so a button held through reset release is not a press.
//  btn path: 2-FF synchronizer, then rising-edge detect -> one-cycle press pulse.
//   Latency: btn rises, press pulse occurs 2-3 clk later, register/state update on the following edge.
//  Transitions (clr has priority over press):
//   IDLE   + press : a_out<=in; ->HAVE_A
//   HAVE_A + press : b_out<=in; ->HAVE_B
//   HAVE_B         : unconditional, one cycle: {cout,sum}<=a_out+b_out (WIDTH+1 bits); result_valid<=1;
//                    ovf_cnt+=cout_new unless already 15; hold counter<=0; ->SHOW
//                    a press arriving in HAVE_B is dropped
//   SHOW   + press : exit (see CONFIGURATION)
//   SHOW   no press: hold counter++; at HOLD_CYCLES-1 -> IDLE, clearing a_out, b_out, sum, cout and result_valid
//                    (timeout exit is the same with or without the macro)
//   clr, any state : ->IDLE; a_out, b_out, sum, cout, result_valid, ovf_cnt, hold counter <=0
//  Register hold rules:
//   - Outputs hold their value except on the listed transitions.
//   - sum/cout change only in HAVE_B or when cleared.
//  Wrap-around:
//   - 0xFF+0x01 -> sum=0x00, cout=1.
//   - 0xFF+0xFF -> sum=0xFE, cout=1.
//  Simultaneous events:
//   - Press coincident with the timeout terminal count: press wins.
//   - Press and clr in the same cycle: clr wins.
//  areset asserted mid-operation clears everything immediately (async); no partial result survives.
// CONFIGURATION
//  Macro SEQ_ACCUM_CHAIN_EN.
//  Defined (chained add), SHOW + press: a_out<=sum; b_out<=0; sum,cout,result_valid<=0; ->HAVE_A.
//   The next press loads B, giving a running sum.
//  Undefined, SHOW + press: a_out, b_out, sum, cout, result_valid <=0; ->IDLE.
//  ovf_cnt behaves identically in both builds.
// TESTING  (WIDTH=8, HOLD_CYCLES=8)
//  1 Reset: btn=1 held across areset release -> all outputs 0, state=00, no press registered.
//  2 Basic add: in=0x3C press, in=0x05 press -> state 10 for one cycle, then 11; sum=0x41, cout=0, result_valid=1.
//  3 Carry: 0xFF + 0x01 -> sum=0x00, cout=1, ovf_cnt=1.
//    16 such adds -> ovf_cnt stays 15.
//  4 Timeout: after test 2, no press for 8 cycles in SHOW -> state=00, a_out/b_out/sum/cout/result_valid all 0.
//  5 Priority: in HAVE_A (a_out=0x11), press and clr in the same cycle -> state=00, b_out=0, a_out=0.
//  6 SEQ_ACCUM_CHAIN_EN:
//    0x10 + 0x20 -> sum=0x30; press -> a_out=0x30, state=01;
//    in=0x05 press -> sum=0x35.
//    Without the macro, the same press -> state=00.

Source files
------------

// File: rtl/adder_op_sequencer.sv
// adder_op_sequencer: two-operand entry sequencer for the 8-bit adder/display
// datapath. One switch bank and one step button load operand A, then operand B.
// The sum and carry are then computed and held for the hex decoders until a
// press or a hold timeout.
//
// Build option: define SEQ_ACCUM_CHAIN_EN for chained (running-sum) operation.
// With it, a press in SHOW feeds the sum back as operand A. Without it
// (default), a press in SHOW clears the datapath and returns to IDLE.

module adder_op_sequencer #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in,
  input  logic             btn,
  input  logic             clr,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             result_valid,
  output logic [1:0]       state,
  output logic [3:0]       ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    HAVE_B = 2'b10,
    SHOW   = 2'b11
  } state_t;

  // The hold counter only has to reach HOLD_CYCLES-1.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

  state_t            state_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_prev;
  logic [1:0]        sync_fill;
  logic              press;
  logic              hold_done;
  logic [WIDTH:0]    add_full;

  // Button synchronizer and rising-edge detector.
  // btn_prev is forced high while the synchronizer fills after reset.
  // A button held through reset release therefore looks already pressed
  // and never produces a spurious press pulse.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_prev  <= 1'b1;
      sync_fill <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let btn_s2 take the old btn_s1, forming a real two-stage chain.
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      if (sync_fill != 2'd2) begin
        sync_fill <= sync_fill + 2'd1;
        btn_prev  <= 1'b1;
      end else begin
        btn_prev  <= btn_s2;
      end
    end
  end

  assign press     = btn_s2 & ~btn_prev;
  assign hold_done = (HOLD_CYCLES != 0) && (hold_cnt == HOLD_LAST);
  assign add_full  = {1'b0, a_out} + {1'b0, b_out};
  assign state     = state_q;

  // Operand-entry FSM with registered datapath outputs; clr overrides everything.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q      <= IDLE;
      a_out        <= '0;
      b_out        <= '0;
      sum          <= '0;
      cout         <= 1'b0;
      result_valid <= 1'b0;
      ovf_cnt      <= 4'd0;
      hold_cnt     <= '0;
    end else if (clr) begin
      state_q      <= IDLE;
      a_out        <= '0;
      b_out        <= '0;
      sum          <= '0;
      cout         <= 1'b0;
      result_valid <= 1'b0;
      ovf_cnt      <= 4'd0;
      hold_cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press) begin
            a_out   <= in;
            state_q <= HAVE_A;
          end
        end
        HAVE_A: begin
          if (press) begin
            b_out   <= in;
            state_q <= HAVE_B;
          end
        end
        HAVE_B: begin
          // Single compute cycle; any press landing here is ignored.
          {cout, sum}  <= add_full;
          result_valid <= 1'b1;
          if (add_full[WIDTH] && (ovf_cnt != 4'hF)) begin
            ovf_cnt <= ovf_cnt + 4'd1;
          end
          hold_cnt <= '0;
          state_q  <= SHOW;
        end
        SHOW: begin
          if (press) begin
`ifdef SEQ_ACCUM_CHAIN_EN
            a_out        <= sum;
            b_out        <= '0;
            sum          <= '0;
            cout         <= 1'b0;
            result_valid <= 1'b0;
            state_q      <= HAVE_A;
`else
            a_out        <= '0;
            b_out        <= '0;
            sum          <= '0;
            cout         <= 1'b0;
            result_valid <= 1'b0;
            state_q      <= IDLE;
`endif
          end else if (hold_done) begin
            a_out        <= '0;
            b_out        <= '0;
            sum          <= '0;
            cout         <= 1'b0;
            result_valid <= 1'b0;
            state_q      <= IDLE;
          end else if (HOLD_CYCLES != 0) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Directed testbench for adder_op_sequencer (WIDTH=8, HOLD_CYCLES=8).
// Define SEQ_ACCUM_CHAIN_EN for both the bench and the RTL to check the chained build.

module tb_adder_op_sequencer;

  logic       clk;
  logic       areset;
  logic [7:0] in;
  logic       btn;
  logic       clr;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [7:0] sum;
  logic       cout;
  logic       result_valid;
  logic [1:0] state;
  logic [3:0] ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  adder_op_sequencer #(
    .WIDTH       (8),
    .HOLD_CYCLES (8)
  ) dut (
    .clk          (clk),
    .areset       (areset),
    .in           (in),
    .btn          (btn),
    .clr          (clr),
    .a_out        (a_out),
    .b_out        (b_out),
    .sum          (sum),
    .cout         (cout),
    .result_valid (result_valid),
    .state        (state),
    .ovf_cnt      (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press sequence: hold btn low for two edges, then raise it with in=val.
  // The state update lands on the third rising edge after the rise.
  // Returns 1 ns after that update edge. If with_clr is set, clr is high for
  // that same edge.
  task automatic do_press(input logic [7:0] val, input logic with_clr);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in  = val;
    btn = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = with_clr;
    @(posedge clk);
    #1;
    btn = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b0;
    btn    = 1'b1;
    clr    = 1'b0;
    in     = 8'h00;

    // Reset state, with the button held high throughout.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'h0);
    check("rst_a", 32'(a_out), 32'h0);
    check("rst_b", 32'(b_out), 32'h0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_rv", 32'(result_valid), 32'h0);
    check("rst_ovf", 32'(ovf_cnt), 32'h0);
    @(negedge clk);
    areset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("held_btn_state", 32'(state), 32'h0);
    check("held_btn_a", 32'(a_out), 32'h0);
    @(negedge clk);
    btn = 1'b0;
    repeat (4) @(posedge clk);

    // Basic add: 0x3C + 0x05 = 0x41.
    do_press(8'h3C, 1'b0);
    check("add_a_state", 32'(state), 32'h1);
    check("add_a_val", 32'(a_out), 32'h3C);
    do_press(8'h05, 1'b0);
    check("add_b_state", 32'(state), 32'h2);
    check("add_b_val", 32'(b_out), 32'h05);
    check("add_b_rv", 32'(result_valid), 32'h0);
    @(posedge clk);
    #1;
    check("add_show_state", 32'(state), 32'h3);
    check("add_sum", 32'(sum), 32'h41);
    check("add_cout", 32'(cout), 32'h0);
    check("add_rv", 32'(result_valid), 32'h1);
    check("add_ovf", 32'(ovf_cnt), 32'h0);

    // Timeout: SHOW lasts 8 cycles, then returns to IDLE with the datapath cleared.
    repeat (7) @(posedge clk);
    #1;
    check("to_still_show", 32'(state), 32'h3);
    @(posedge clk);
    #1;
    check("to_state", 32'(state), 32'h0);
    check("to_a", 32'(a_out), 32'h0);
    check("to_b", 32'(b_out), 32'h0);
    check("to_sum", 32'(sum), 32'h0);
    check("to_cout", 32'(cout), 32'h0);
    check("to_rv", 32'(result_valid), 32'h0);

    // Carry: 16 adds of 0xFF + 0x01. The overflow count saturates at 15.
    for (int i = 0; i < 16; i++) begin
      do_press(8'hFF, 1'b0);
      do_press(8'h01, 1'b0);
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("carry_sum", 32'(sum), 32'h00);
        check("carry_cout", 32'(cout), 32'h1);
        check("carry_ovf1", 32'(ovf_cnt), 32'h1);
      end
      repeat (8) @(posedge clk);
    end
    #1;
    check("carry_ovf_sat", 32'(ovf_cnt), 32'hF);
    check("carry_idle", 32'(state), 32'h0);

    // Priority: press and clr in the same cycle while in HAVE_A; clr wins.
    do_press(8'h11, 1'b0);
    check("prio_a", 32'(a_out), 32'h11);
    do_press(8'h22, 1'b1);
    check("prio_state", 32'(state), 32'h0);
    check("prio_a_clr", 32'(a_out), 32'h0);
    check("prio_b_clr", 32'(b_out), 32'h0);
    check("prio_ovf_clr", 32'(ovf_cnt), 32'h0);

    // SHOW + press: chained accumulate or return to IDLE, depending on the build.
    do_press(8'h10, 1'b0);
    do_press(8'h20, 1'b0);
    @(posedge clk);
    #1;
    check("chain_sum1", 32'(sum), 32'h30);
    do_press(8'h05, 1'b0);
`ifdef SEQ_ACCUM_CHAIN_EN
    check("chain_state", 32'(state), 32'h1);
    check("chain_a", 32'(a_out), 32'h30);
    check("chain_sum_clr", 32'(sum), 32'h00);
    do_press(8'h05, 1'b0);
    @(posedge clk);
    #1;
    check("chain_sum2", 32'(sum), 32'h35);
`else
    check("exit_state", 32'(state), 32'h0);
    check("exit_a", 32'(a_out), 32'h0);
    check("exit_rv", 32'(result_valid), 32'h0);
`endif

    // Asynchronous reset mid-operation clears everything without a clock edge.
    repeat (10) @(posedge clk);
    do_press(8'h5A, 1'b0);
    check("mid_a", 32'(a_out), 32'h5A);
    @(negedge clk);
    #2 areset = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'h0);
    check("arst_a", 32'(a_out), 32'h0);
    check("arst_ovf", 32'(ovf_cnt), 32'h0);
    @(negedge clk);
    areset = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
